// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART program-image loader that fills instruction memory and releases the core
module uart_boot_loader #(
    parameter int          ADDR_WIDTH     = 10,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_core_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERR
    } state_t;

    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    state_t                state;
    state_t                state_next;
    logic [7:0]            len_lo;
    logic [15:0]           len_m1;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_cnt;
    logic [23:0]           word_sr;
    logic [7:0]            csum;
    logic [TW-1:0]         idle_cnt;
    logic                  busy;
    logic                  timeout;
    logic                  word_done;
    logic [16:0]           len_full;

    assign busy      = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CHECK);
    assign timeout   = busy && !i_rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign word_done = (state == S_DATA) && i_rx_valid && (byte_cnt == 2'd3);
    assign len_full  = {1'b0, i_rx_data, len_lo};

    assign o_busy  = busy;
    assign o_done  = (state == S_RUN);
    assign o_error = (state == S_ERR);

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = S_ERR;
        end else if (i_rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (i_rx_data == SYNC_BYTE) state_next = S_LEN_LO;
                end
                S_LEN_LO: state_next = S_LEN_HI;
                S_LEN_HI: begin
                    if (len_full > MAX_LEN)
                        state_next = S_ERR;
                    else if (len_full == 17'd0)
                        state_next = S_CHECK;
                    else
                        state_next = S_DATA;
                end
                S_DATA: begin
                    if (byte_cnt == 2'd3 && 16'(word_idx) == len_m1)
                        state_next = S_CHECK;
                end
                S_CHECK: state_next = (i_rx_data == csum) ? S_RUN : S_ERR;
                S_RUN:   state_next = S_RUN;
                S_ERR: begin
                    if (i_rx_data == SYNC_BYTE) state_next = S_LEN_LO;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_core_rst   <= 1'b1;
            len_lo       <= '0;
            len_m1       <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            word_sr      <= '0;
            csum         <= '0;
            idle_cnt     <= '0;
        end else begin
            state      <= state_next;
            // Registered so the core leaves reset one cycle after RUN is reached.
            o_core_rst <= (state != S_RUN);
            o_imem_we  <= word_done;

            if (!busy || i_rx_valid)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TW'(1);

            if (word_done) begin
                o_imem_addr  <= word_idx;
                o_imem_wdata <= {i_rx_data, word_sr};
                word_idx     <= word_idx + ADDR_WIDTH'(1);
            end

            if (i_rx_valid && !timeout) begin
                case (state)
                    S_LEN_LO: len_lo <= i_rx_data;
                    S_LEN_HI: len_m1 <= {i_rx_data, len_lo} - 16'd1;
                    S_DATA: begin
                        word_sr  <= {i_rx_data, word_sr[23:8]};
                        csum     <= csum ^ i_rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end

            // A fresh frame (from IDLE or ERR) restarts addressing and the checksum.
            if (state_next == S_LEN_LO && state != S_LEN_LO) begin
                word_idx <= '0;
                csum     <= '0;
                byte_cnt <= '0;
            end
        end
    end

endmodule
